// File: rtl/branch_resolve_bht_pkg.sv
// rtl/branch_resolve_bht_pkg.sv - BHT counter states, opcode and op-class codes for branch resolution
package branch_resolve_bht_pkg;

    localparam logic [1:0] BHT_SNT = 2'd0;
    localparam logic [1:0] BHT_WNT = 2'd1;
    localparam logic [1:0] BHT_WT  = 2'd2;
    localparam logic [1:0] BHT_ST  = 2'd3;
    localparam logic [1:0] BHT_RESET_STATE = BHT_WNT;

    localparam logic [7:0] OP_JIRL = 8'h01;
    localparam logic [7:0] OP_B    = 8'h02;
    localparam logic [7:0] OP_BL   = 8'h03;
    localparam logic [7:0] OP_BEQ  = 8'h04;
    localparam logic [7:0] OP_BNE  = 8'h05;
    localparam logic [7:0] OP_BLT  = 8'h06;
    localparam logic [7:0] OP_BGE  = 8'h07;
    localparam logic [7:0] OP_BLTU = 8'h08;
    localparam logic [7:0] OP_BGEU = 8'h09;

    localparam logic [2:0] OP_TYPE_ALU = 3'd0;
    localparam logic [2:0] OP_TYPE_MEM = 3'd1;
    localparam logic [2:0] OP_TYPE_MUL = 3'd2;
    localparam logic [2:0] OP_TYPE_BJ  = 3'd3;

    function automatic logic is_cond_branch(input logic [7:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/branch_resolve_bht_sat_counter2.sv
// rtl/branch_resolve_bht_sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
    import branch_resolve_bht_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (taken) begin
            if (cur != BHT_ST) next = cur + 2'd1;
        end else begin
            if (cur != BHT_SNT) next = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - EX branch resolution with direct-mapped 2-bit BHT; BRANCH_PERF_EN adds perf counters
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [7:0]      ex_op,
    input  logic [2:0]      ex_op_type,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rj,
    input  logic [XLEN-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            resolve_taken
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0]     perf_branch_cnt,
    output logic [31:0]     perf_mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       r_bht [BHT_DEPTH];
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_resolve_taken;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_accept;
    logic             w_taken;
    logic             w_known;
    logic             w_mispred;
    logic             w_upd_en;
    logic [XLEN-1:0]  w_next_pc;
    logic [1:0]       w_bht_next;

    assign w_if_idx   = if_pc[IDX_LSB +: IDX_W];
    assign w_ex_idx   = ex_pc[IDX_LSB +: IDX_W];
    // Lookup reads the registered table only, so a same-cycle update is not bypassed
    assign pred_taken = r_bht[w_if_idx][1];

    assign w_accept = ex_valid && !flush && (ex_op_type == OP_TYPE_BJ);

    always_comb begin
        w_taken = 1'b0;
        w_known = 1'b1;
        case (ex_op)
            OP_JIRL, OP_B, OP_BL: w_taken = 1'b1;
            OP_BEQ:  w_taken = (ex_rj == ex_rd);
            OP_BNE:  w_taken = (ex_rj != ex_rd);
            OP_BLT:  w_taken = ($signed(ex_rj) <  $signed(ex_rd));
            OP_BGE:  w_taken = ($signed(ex_rj) >= $signed(ex_rd));
            OP_BLTU: w_taken = (ex_rj <  ex_rd);
            OP_BGEU: w_taken = (ex_rj >= ex_rd);
            default: w_known = 1'b0;
        endcase
    end

    // Unknown opcodes resolve not-taken but never force a redirect
    assign w_mispred = w_accept && w_known && (w_taken != ex_pred_taken);
    assign w_next_pc = w_taken ? ex_target : (ex_pc + XLEN'(4));
    assign w_upd_en  = w_accept && is_cond_branch(ex_op);

    sat_counter2 u_sat_counter2 (
        .cur   (r_bht[w_ex_idx]),
        .taken (w_taken),
        .next  (w_bht_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= BHT_RESET_STATE;
        end else if (w_upd_en) begin
            r_bht[w_ex_idx] <= w_bht_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_resolve_taken  <= 1'b0;
        end else begin
            r_redirect_valid <= w_mispred;
            if (w_accept) begin
                r_redirect_pc   <= w_next_pc;
                r_resolve_taken <= w_taken;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign resolve_taken  = r_resolve_taken;

`ifdef BRANCH_PERF_EN
    logic [31:0] r_perf_branch_cnt;
    logic [31:0] r_perf_mispred_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_branch_cnt  <= '0;
            r_perf_mispred_cnt <= '0;
        end else begin
            if (w_accept)  r_perf_branch_cnt  <= r_perf_branch_cnt + 32'd1;
            if (w_mispred) r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
        end
    end

    assign perf_branch_cnt  = r_perf_branch_cnt;
    assign perf_mispred_cnt = r_perf_mispred_cnt;
`endif

endmodule
